// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared seven-segment constants and helpers for the BCD scan
//               counter family. Patterns are active-low, bit 6 = a ... 0 = g.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Decode one BCD nibble; anything outside 0..9 shows nothing.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Ceiling log2, used at elaboration time for counter widths.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit
// Description : One decade of the BCD up/down counter. Steps when en_i is
//               high, loads (with out-of-range nibbles forced to 0) when
//               load_i is high, and reports carry/borrow to the next decade.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module bcd_digit (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic       en_i,
  input  logic       up_i,
  input  logic       load_i,
  input  logic [3:0] d_in_i,
  output logic [3:0] q_o,
  output logic       carry_out_o,
  output logic       borrow_out_o
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // Next digit value: load beats a step; steps wrap 9->0 / 0->9.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = (d_in_i > 4'd9) ? 4'd0 : d_in_i;
    end else if (en_i) begin
      if (up_i) q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
      else      q_d = (q_q == 4'd0) ? 4'd9 : q_q - 4'd1;
    end
  end

  // Digit register, cleared asynchronously.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) q_q <= 4'd0;
    else       q_q <= q_d;
  end

  assign q_o          = q_q;
  // The next decade steps only when this one rolls over in the step direction.
  assign carry_out_o  = en_i &&  up_i && (q_q == 4'd9);
  assign borrow_out_o = en_i && !up_i && (q_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/seg7_bcd_scan_counter.sv
`default_nettype none
// ============================================================================
// Module      : seg7_bcd_scan_counter
// Description : N-digit BCD up/down counter with load, rate prescaler,
//               multiplexed common-anode display scan, leading-zero blanking
//               and a wrap pulse. All display outputs are registered.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module seg7_bcd_scan_counter
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_HZ       = 100_000_000,
  parameter int TICK_HZ      = 1,
  parameter int REFRESH_BITS = 18
) (
  input  logic                    clock_100Mhz,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    blank_lz,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    wrap,
  output logic [NUM_DIGITS-1:0]   Anode_Activate,
  output logic [6:0]              LED_out
);

  localparam int                DIV      = CLK_HZ / TICK_HZ;
  localparam int                PRE_W    = clog2(DIV);
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(DIV - 1);
  localparam int                SCAN_W   = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------- prescaler
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic             tick;

  assign tick = enable && (pre_q == PRE_MAX);

  // Prescaler next value: load restarts the interval, enable=0 freezes it.
  always_comb begin
    pre_d = pre_q;
    if (load)        pre_d = '0;
    else if (enable) pre_d = tick ? '0 : pre_q + PRE_W'(1);
  end

  // Prescaler register.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) pre_q <= '0;
    else       pre_q <= pre_d;
  end

  // ------------------------------------------------------------- digit chain
  // step_en[i] enables decade i; the bit past the top decade is the wrap.
  logic [NUM_DIGITS:0]   step_en;
  logic [NUM_DIGITS-1:0] carry;
  logic [NUM_DIGITS-1:0] borrow;

  assign step_en[0] = tick && !load;

  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .en_i         (step_en[i]),
        .up_i         (up_down),
        .load_i       (load),
        .d_in_i       (load_value[4*i +: 4]),
        .q_o          (count_bcd[4*i +: 4]),
        .carry_out_o  (carry[i]),
        .borrow_out_o (borrow[i])
      );
      assign step_en[i+1] = carry[i] | borrow[i];
    end
  endgenerate

  logic wrap_q;

  // Wrap pulse registered on the same edge as the rolling count update.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) wrap_q <= 1'b0;
    else       wrap_q <= step_en[NUM_DIGITS];
  end

  assign wrap = wrap_q;

  // ------------------------------------------------------------- scan timing
  logic [REFRESH_BITS-1:0] refresh_q;
  logic [SCAN_W-1:0]       scan_q;
  logic [SCAN_W-1:0]       scan_d;

  // Scan index moves on when the refresh counter is about to roll over.
  always_comb begin
    scan_d = scan_q;
    if (&refresh_q) scan_d = (scan_q == SCAN_MAX) ? '0 : scan_q + SCAN_W'(1);
  end

  // Free-running refresh counter and scan index, unaffected by enable/load.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      refresh_q <= '0;
      scan_q    <= '0;
    end else begin
      refresh_q <= refresh_q + REFRESH_BITS'(1);
      scan_q    <= scan_d;
    end
  end

  // ---------------------------------------------------------------- blanking
  // blank_ok[i]: digit i and every digit above it are zero (never for digit 0).
  logic [NUM_DIGITS-1:0] blank_ok;

  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_blank
      if (i == 0) begin : g_lsd
        assign blank_ok[i] = 1'b0;
      end else if (i == NUM_DIGITS - 1) begin : g_msd
        assign blank_ok[i] = (count_bcd[4*i +: 4] == 4'd0);
      end else begin : g_mid
        assign blank_ok[i] = blank_ok[i+1] && (count_bcd[4*i +: 4] == 4'd0);
      end
    end
  endgenerate

  // ------------------------------------------------------------ display regs
  logic [NUM_DIGITS-1:0] an_q;
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            led_q;
  logic [6:0]            led_d;
  logic [3:0]            digit_sel;
  logic                  blank_sel;

  // Select the active digit and build anode/cathode values for it.
  always_comb begin
    an_d      = '1;
    led_d     = SEG_BLANK;
    digit_sel = 4'd0;
    blank_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_q == SCAN_W'(i)) begin
        digit_sel = count_bcd[4*i +: 4];
        blank_sel = blank_lz && blank_ok[i];
      end
    end
    if (!blank_sel) begin
      led_d = bcd_to_seg(digit_sel);
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_d[i] = (scan_q != SCAN_W'(i));
      end
    end
  end

  // Anodes and cathodes share one edge so no mixed-digit cycle appears.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      an_q  <= '1;
      led_q <= SEG_BLANK;
    end else begin
      an_q  <= an_d;
      led_q <= led_d;
    end
  end

  assign Anode_Activate = an_q;
  assign LED_out        = led_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_bcd_scan_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_bcd_scan_counter
// Description : Self-checking bench for seg7_bcd_scan_counter with small
//               rates (DIV=10, 4-cycle digit dwell). A reference model
//               predicts every edge; a scoreboard compares DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_bcd_scan_counter;

  localparam int ND = 4;

  logic        clock_100Mhz = 1'b0;
  logic        reset        = 1'b1;
  logic        enable       = 1'b0;
  logic        up_down      = 1'b1;
  logic        load         = 1'b0;
  logic [15:0] load_value   = 16'h0000;
  logic        blank_lz     = 1'b0;
  logic [15:0] count_bcd;
  logic        wrap;
  logic [3:0]  Anode_Activate;
  logic [6:0]  LED_out;

  seg7_bcd_scan_counter #(
    .NUM_DIGITS   (ND),
    .CLK_HZ       (10),
    .TICK_HZ      (1),
    .REFRESH_BITS (2)
  ) dut (
    .clock_100Mhz   (clock_100Mhz),
    .reset          (reset),
    .enable         (enable),
    .up_down        (up_down),
    .load           (load),
    .load_value     (load_value),
    .blank_lz       (blank_lz),
    .count_bcd      (count_bcd),
    .wrap           (wrap),
    .Anode_Activate (Anode_Activate),
    .LED_out        (LED_out)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  typedef struct packed {
    logic [15:0] count;
    logic        wrap;
    logic [3:0]  an;
    logic [6:0]  led;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   errors = 0;
  int   checks = 0;

  // Reference model state: decimal count, prescaler, refresh phase, scan index.
  int m_count = 0;
  int m_pre   = 0;
  int m_ref   = 0;
  int m_s     = 0;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int load_to_int(input logic [15:0] b);
    int sum;
    int p;
    int d;
    sum = 0;
    p   = 1;
    for (int i = 0; i < 4; i++) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) d = 0;
      sum = sum + d * p;
      p   = p * 10;
    end
    return sum;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       return 7'b0000001;
      1:       return 7'b1001111;
      2:       return 7'b0010010;
      3:       return 7'b0000110;
      4:       return 7'b1001100;
      5:       return 7'b0100100;
      6:       return 7'b0100000;
      7:       return 7'b0001111;
      8:       return 7'b0000000;
      9:       return 7'b0000100;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic void model_reset();
    m_count = 0;
    m_pre   = 0;
    m_ref   = 0;
    m_s     = 0;
  endfunction

  // Predict the coming edge from the current inputs, queue it, run the edge.
  task automatic step();
    exp_t e;
    int   p;
    int   d;
    bit   blank;
    p = 1;
    for (int k = 0; k < m_s; k++) p = p * 10;
    d     = (m_count / p) % 10;
    blank = blank_lz && (m_s != 0) && (m_count < p);
    if (blank) begin
      e.an  = 4'hF;
      e.led = 7'h7F;
    end else begin
      e.an  = ~(4'b0001 << m_s);
      e.led = seg_of(d);
    end
    if (m_ref == 3) begin
      m_ref = 0;
      m_s   = (m_s + 1) % ND;
    end else begin
      m_ref = m_ref + 1;
    end
    e.wrap = 1'b0;
    if (load) begin
      m_count = load_to_int(load_value);
      m_pre   = 0;
    end else if (enable) begin
      if (m_pre == 9) begin
        m_pre = 0;
        if (up_down) begin
          if (m_count == 9999) begin m_count = 0; e.wrap = 1'b1; end
          else m_count = m_count + 1;
        end else begin
          if (m_count == 0) begin m_count = 9999; e.wrap = 1'b1; end
          else m_count = m_count - 1;
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
    e.count = to_bcd(m_count);
    sb_q.push_back(e);
    @(posedge clock_100Mhz);
    #2;
  endtask

  // Scoreboard comparator: one queued prediction per clock edge.
  always @(posedge clock_100Mhz) begin
    #1;
    if (sb_q.size() > 0) begin
      sb_e = sb_q.pop_front();
      checks++;
      if (count_bcd !== sb_e.count) begin
        errors++;
        $display("FAIL sb_count t=%0t got=%h exp=%h", $time, count_bcd, sb_e.count);
      end
      checks++;
      if (wrap !== sb_e.wrap) begin
        errors++;
        $display("FAIL sb_wrap t=%0t got=%b exp=%b", $time, wrap, sb_e.wrap);
      end
      checks++;
      if (Anode_Activate !== sb_e.an) begin
        errors++;
        $display("FAIL sb_anode t=%0t got=%b exp=%b", $time, Anode_Activate, sb_e.an);
      end
      checks++;
      if (LED_out !== sb_e.led) begin
        errors++;
        $display("FAIL sb_led t=%0t got=%b exp=%b", $time, LED_out, sb_e.led);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks++;
    if (count_bcd !== 16'h0000) begin errors++; $display("FAIL reset_count got=%h exp=0000", count_bcd); end
    checks++;
    if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    checks++;
    if (Anode_Activate !== 4'hF) begin errors++; $display("FAIL reset_anode got=%b exp=1111", Anode_Activate); end
    checks++;
    if (LED_out !== 7'h7F) begin errors++; $display("FAIL reset_led got=%h exp=7f", LED_out); end
    @(negedge clock_100Mhz);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_count_up();
    logic [15:0] prev;
    int first;
    int second;
    first   = 0;
    second  = 0;
    enable  = 1'b1;
    up_down = 1'b1;
    prev    = count_bcd;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (count_bcd !== prev) begin
        if (first == 0) first = k;
        else if (second == 0) second = k;
        prev = count_bcd;
      end
    end
    checks++;
    if (count_bcd !== 16'h0002) begin errors++; $display("FAIL up25_count got=%h exp=0002", count_bcd); end
    checks++;
    if (first != 10) begin errors++; $display("FAIL first_tick got=%0d exp=10", first); end
    checks++;
    if (second != 20) begin errors++; $display("FAIL second_tick got=%0d exp=20", second); end
  endtask

  task automatic test_wrap_up();
    int wraps;
    wraps      = 0;
    up_down    = 1'b1;
    load       = 1'b1;
    load_value = 16'h9998;
    step();
    load = 1'b0;
    checks++;
    if (count_bcd !== 16'h9998) begin errors++; $display("FAIL load_9998 got=%h exp=9998", count_bcd); end
    for (int k = 0; k < 20; k++) begin
      step();
      if (wrap === 1'b1) wraps++;
    end
    checks++;
    if (count_bcd !== 16'h0000) begin errors++; $display("FAIL up_wrap_count got=%h exp=0000", count_bcd); end
    checks++;
    if (wrap !== 1'b1) begin errors++; $display("FAIL up_wrap_edge got=%b exp=1", wrap); end
    checks++;
    if (wraps != 1) begin errors++; $display("FAIL up_wrap_pulses got=%0d exp=1", wraps); end
    step();
    checks++;
    if (wrap !== 1'b0) begin errors++; $display("FAIL up_wrap_width got=%b exp=0", wrap); end
  endtask

  task automatic test_wrap_down();
    int wraps;
    wraps      = 0;
    up_down    = 1'b0;
    load       = 1'b1;
    load_value = 16'h0001;
    step();
    load = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (wrap === 1'b1) wraps++;
    end
    checks++;
    if (count_bcd !== 16'h9999) begin errors++; $display("FAIL down_wrap_count got=%h exp=9999", count_bcd); end
    checks++;
    if (wraps != 1) begin errors++; $display("FAIL down_wrap_pulses got=%0d exp=1", wraps); end
    load       = 1'b1;
    load_value = 16'h12F4;
    step();
    load = 1'b0;
    checks++;
    if (count_bcd !== 16'h1204) begin errors++; $display("FAIL load_bad_nibble got=%h exp=1204", count_bcd); end
  endtask

  task automatic test_load_on_tick();
    int guard;
    int n;
    up_down = 1'b1;
    enable  = 1'b1;
    guard   = 0;
    while (m_pre != 9 && guard < 20) begin
      step();
      guard++;
    end
    if (guard >= 20) begin
      checks++;
      errors++;
      $display("FAIL tick_align got=%0d exp=<20 cycles", guard);
    end
    load       = 1'b1;
    load_value = 16'h0500;
    step();
    load = 1'b0;
    checks++;
    if (count_bcd !== 16'h0500) begin errors++; $display("FAIL load_beats_tick got=%h exp=0500", count_bcd); end
    n = 0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (n == 0 && count_bcd !== 16'h0500) n = k;
    end
    checks++;
    if (n != 10) begin errors++; $display("FAIL tick_after_load got=%0d exp=10", n); end
    checks++;
    if (count_bcd !== 16'h0501) begin errors++; $display("FAIL step_after_load got=%h exp=0501", count_bcd); end
  endtask

  task automatic test_blanking();
    int nb;
    int n1;
    int n0;
    int nz;
    nb = 0; n1 = 0; n0 = 0; nz = 0;
    enable     = 1'b0;
    load       = 1'b1;
    load_value = 16'h0042;
    step();
    load     = 1'b0;
    blank_lz = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      if (Anode_Activate === 4'b1111 && LED_out === 7'h7F)             nb++;
      else if (Anode_Activate === 4'b1101 && LED_out === 7'b1001100)   n1++;
      else if (Anode_Activate === 4'b1110 && LED_out === 7'b0010010)   n0++;
    end
    checks++;
    if (nb != 8) begin errors++; $display("FAIL blank_upper got=%0d exp=8 cycles", nb); end
    checks++;
    if (n1 != 4) begin errors++; $display("FAIL digit1_four got=%0d exp=4 cycles", n1); end
    checks++;
    if (n0 != 4) begin errors++; $display("FAIL digit0_two got=%0d exp=4 cycles", n0); end
    blank_lz = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      if ((Anode_Activate === 4'b0111 || Anode_Activate === 4'b1011) && LED_out === 7'b0000001) nz++;
    end
    checks++;
    if (nz != 8) begin errors++; $display("FAIL unblanked_zeros got=%0d exp=8 cycles", nz); end
  endtask

  task automatic test_reset_mid();
    int guard;
    bit found;
    enable     = 1'b0;
    load       = 1'b1;
    load_value = 16'h0731;
    step();
    load  = 1'b0;
    found = 1'b0;
    guard = 0;
    while (!found && guard < 12) begin
      step();
      guard++;
      if (Anode_Activate === 4'b1011) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL reach_scan2 got=%b exp=1011", Anode_Activate); end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (count_bcd !== 16'h0000) begin errors++; $display("FAIL async_count got=%h exp=0000", count_bcd); end
    checks++;
    if (wrap !== 1'b0) begin errors++; $display("FAIL async_wrap got=%b exp=0", wrap); end
    checks++;
    if (Anode_Activate !== 4'hF) begin errors++; $display("FAIL async_anode got=%b exp=1111", Anode_Activate); end
    checks++;
    if (LED_out !== 7'h7F) begin errors++; $display("FAIL async_led got=%h exp=7f", LED_out); end
    repeat (2) @(posedge clock_100Mhz);
    @(negedge clock_100Mhz);
    reset = 1'b0;
    model_reset();
    enable = 1'b1;
    for (int k = 0; k < 12; k++) step();
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_load_on_tick();
    test_blanking();
    test_reset_mid();
    #20;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t exp=finish before timeout", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/seg7_bcd_scan_counter.md
# seg7_bcd_scan_counter

Parametrised successor to the team's fixed 4-digit seven-segment controller. It provides an N-digit decimal up/down counter with synchronous load, a configurable count rate and a configurable multiplex refresh rate. Leading-zero blanking and a wrap pulse are included, and all display outputs are glitch-free registered. It sits between board I/O (switches/buttons, already synchronised upstream) and the common-anode display pins on the Basys-3-class boards.

## Interface
- NUM_DIGITS, 4, displayed/counted decimal digits (1..8)
- CLK_HZ, 100_000_000, input clock frequency
- TICK_HZ, 1, count-step rate; DIV = CLK_HZ/TICK_HZ (integer, ≥2)
- REFRESH_BITS, 18, per-digit on-time = 2^REFRESH_BITS cycles (2.62 ms at 100 MHz)
- clock_100Mhz  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  1 = prescaler and counting run; 0 = freeze both (scan continues)
- up_down  in  1  1 = count up, 0 = count down
- load  in  1  synchronous load strobe
- load_value  in  4*NUM_DIGITS  BCD value to load, digit 0 in [3:0]
- blank_lz  in  1  1 = blank leading zeros
- count_bcd  out  4*NUM_DIGITS  current count, BCD
- wrap  out  1  one-cycle pulse on 9…9→0 (up) or 0→9…9 (down)
- Anode_Activate  out  NUM_DIGITS  active-low digit enables, bit i = digit i (0 = least significant)
- LED_out  out  7  active-low cathodes, bit 6 = a … bit 0 = g

## Operation
- Prescaler counts 0..DIV-1 while enable=1 and holds while enable=0. tick = enable && prescaler==DIV-1.
- Load has priority over tick. On load=1, count_bcd is set to load_value and the prescaler clears to 0. Any nibble >9 loads as 0. wrap stays 0.
- tick without load steps the count ±1 with a decimal carry/borrow chain across all digits.
- Up from all-9s gives all-0s with wrap=1. Down from all-0s gives all-9s with wrap=1.
- Scan index s counts 0..NUM_DIGITS-1 and advances every 2^REFRESH_BITS cycles. It wraps to 0 after NUM_DIGITS-1, including for non-power-of-2 counts. It is independent of enable and load.
- Active digit s drives Anode_Activate = all ones except bit s = 0, and LED_out = pattern(count digit s).
- Blanking: digit s (s ≠ 0) is blanked when blank_lz=1 and digits NUM_DIGITS-1..s are all 0. A blanked digit gives Anode_Activate all ones and LED_out 7'h7F. Digit 0 is never blanked.
- Patterns: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100. Any other value decodes to 7'h7F.

## Timing
- Reset (async assert, synchronous deassert upstream):
  - count_bcd = 0, prescaler = 0, refresh counter = 0, wrap = 0
  - Anode_Activate = all ones, LED_out = 7'h7F
- Count update: on the clock edge where tick or load is sampled. count_bcd reflects the new value immediately after that edge (0-cycle registered).
- wrap is registered on the same edge as the wrapping update and is high for exactly one cycle.
- Anode_Activate/LED_out are registered: 1-cycle latency from scan index or count change. Both update on the same edge, so no mixed-digit cycle occurs.
- load and tick in the same cycle: load wins and the step is discarded.
- up_down is sampled only on tick edges; changing it mid-interval has no other effect.
- Reset mid-count or mid-scan: all state returns to reset values immediately, without waiting for a clock edge.

## Structure
- Shared package seg7_pkg:
  - seven-segment pattern constants (digits 0–9 and BLANK = 7'h7F)
  - function bcd_to_seg(nibble) returning the pattern
  - function clog2 for scan-index width
- Sub-module bcd_digit: one decade with ports en, up, load, d_in, q, carry_out/borrow_out. It is instantiated NUM_DIGITS times in a ripple chain. The top level holds the prescaler, scan counter, blanking logic and output registers.

## Test plan
Sim overrides: CLK_HZ=10, TICK_HZ=1 (DIV=10), REFRESH_BITS=2, NUM_DIGITS=4.

- Reset then enable=1, up_down=1 for 25 cycles → count_bcd=0x0002. First tick occurs at cycle 10, with exactly 10 cycles between ticks.
- load 0x9998, up → after 2 ticks count_bcd=0x0000 and wrap pulses for 1 cycle on the 9999→0000 edge.
- load 0x0001, up_down=0 → after 2 ticks count_bcd=0x9999 and wrap pulses once. load 0x12F4 → count_bcd=0x1204.
- load asserted on the tick cycle with value 0x0500 → count_bcd=0x0500 (no step), and the next tick comes 10 cycles later.
- count 0x0042, blank_lz=1, run the scan for 16 cycles:
  - digits 3,2 → anodes 1111, LED_out 7'h7F
  - digit 1 → anodes 1101, LED_out 1001100
  - digit 0 → anodes 1110, LED_out 0010010
  - with blank_lz=0, digits 3,2 show 0000001
- Assert reset mid-run (count 0x0731, scan s=2) → outputs immediately go to anodes 1111, LED_out 7'h7F, count 0, wrap 0.
